// File: rtl/at24c02_pkg.sv
// Shared types and constants for the AT24C02 EEPROM target model.
package at24c02_pkg;

  localparam int MEM_BYTES = 256;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEVADDR   = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WADDR     = 4'd3,
    ST_WADDR_ACK = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8
  } state_t;

endpackage

// File: rtl/at24c02_sim_i2c_bus_sync.sv
// SCL/SDA synchronizers plus single-cycle SCL edge and START/STOP pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
  logic [2:0] scl_p;
  logic [2:0] sda_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p <= 3'b111;
      sda_p <= 3'b111;
    end else begin
      scl_p <= {scl_p[1:0], scl_i};
      sda_p <= {sda_p[1:0], sda_i};
    end
  end

  assign sda_s     = sda_p[1];
  assign scl_rise  =  scl_p[1] & ~scl_p[2];
  assign scl_fall  = ~scl_p[1] &  scl_p[2];
  assign start_det =  sda_p[2] & ~sda_p[1] & scl_p[1] & scl_p[2];
  assign stop_det  = ~sda_p[2] &  sda_p[1] & scl_p[1] & scl_p[2];

endmodule

// File: rtl/at24c02_sim.sv
// AT24C02 (256x8) I2C EEPROM target with write-cycle busy window.
// Optional write-protect input enabled by defining AT24C02_WP_EN.
module at24c02_sim
  import at24c02_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int         PAGE_BYTES = 8,
  parameter int         TWR_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
`ifdef AT24C02_WP_EN
  input  logic       wp,
`endif
  output logic [3:0] dbg_state
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_BYTES - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  sh;
  logic [7:0]  ptr;
  logic        rw;
  logic        m_ack;
  logic        wrote;
  logic [31:0] busy;
  logic        wp_blk;
  logic        byte_done;
  logic        mem_we;
  logic [7:0]  rd_byte;

  // Power-up contents model an erased part; reset deliberately leaves them alone.
  logic [7:0] mem [0:MEM_BYTES-1] = '{default: 8'hFF};

`ifdef AT24C02_WP_EN
  assign wp_blk = wp;
`else
  assign wp_blk = 1'b0;
`endif

  assign byte_done = scl_fall && (cnt == 4'd8);
  assign mem_we    = (state == ST_WDATA) && byte_done && !start_det && !stop_det && !wp_blk;
  assign rd_byte   = mem[ptr];
  assign sda_o     = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      sh     <= 8'd0;
      ptr    <= 8'd0;
      rw     <= 1'b0;
      m_ack  <= 1'b0;
      wrote  <= 1'b0;
      busy   <= 32'd0;
      sda_oe <= 1'b0;
    end else begin
      if (busy != 32'd0) busy <= busy - 32'd1;
      if (start_det) begin
        state  <= ST_DEVADDR;
        cnt    <= 4'd0;
        sh     <= 8'd0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        wrote  <= 1'b0;
        if (wrote) busy <= 32'(TWR_CYCLES);
      end else begin
        case (state)
          ST_IDLE: ;
          ST_DEVADDR, ST_WADDR, ST_WDATA: begin
            if (scl_rise && cnt < 4'd8) begin
              sh  <= {sh[6:0], sda_s};
              cnt <= cnt + 4'd1;
            end else if (byte_done) begin
              cnt <= 4'd0;
              if (state == ST_DEVADDR) begin
                // Busy devices ignore their own address, so the master polls with NACKs.
                if (sh[7:1] == DEV_ADDR && busy == 32'd0) begin
                  sda_oe <= 1'b1;
                  rw     <= sh[0];
                  state  <= ST_DEV_ACK;
                end else begin
                  state  <= ST_IDLE;
                end
              end else if (state == ST_WADDR) begin
                ptr    <= sh;
                sda_oe <= 1'b1;
                state  <= ST_WADDR_ACK;
              end else begin
                ptr    <= (ptr & ~PAGE_MASK) | ((ptr + 8'd1) & PAGE_MASK);
                sda_oe <= 1'b1;
                if (!wp_blk) wrote <= 1'b1;
                state  <= ST_WDATA_ACK;
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              cnt <= 4'd0;
              if (rw) begin
                sh     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WADDR;
              end
            end
          end
          ST_WADDR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 8'd1;
                state  <= ST_RACK;
              end else begin
                sda_oe <= ~sh[6];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              m_ack <= ~sda_s;
            end else if (scl_fall) begin
              cnt <= 4'd0;
              if (m_ack) begin
                sh     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_RDATA;
              end else begin
                state  <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_at24c02_sim.sv
// Directed bench for at24c02_sim: bit-banged I2C master on open-drain SDA.
module tb_at24c02_sim;

  localparam int TWR = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o;
  logic       sda_oe;
  logic [3:0] dbg_state;
`ifdef AT24C02_WP_EN
  logic       wp = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  at24c02_sim #(.TWR_CYCLES(TWR)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .sda_oe    (sda_oe),
`ifdef AT24C02_WP_EN
    .wp        (wp),
`endif
    .dbg_state (dbg_state)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Quarter SCL period: 5 clk, so a full bit is 20 clk.
  task automatic q();
    wait_clk(5);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
    end
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    ack = ~sda_line; q();
    scl_m = 1'b0; q();
  endtask

  task automatic recv_byte(input logic ack_out, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b[i] = sda_line; q();
      scl_m = 1'b0; q();
    end
    sda_m = ~ack_out; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o got %b exp 0", sda_o); end
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_byte_write();
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_dev_ack got %b exp 1", ack); end
    send_byte(8'h10, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_waddr_ack got %b exp 1", ack); end
    send_byte(8'hA5, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_data_ack got %b exp 1", ack); end
    i2c_stop();
    wait_clk(TWR + 100);
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rr_dev_ack got %b exp 1", ack); end
    send_byte(8'h10, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rr_waddr_ack got %b exp 1", ack); end
    i2c_start();
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rr_rd_ack got %b exp 1", ack); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rr_data got %h exp a5", d); end
    i2c_stop();
  endtask

  task automatic test_nack_addr();
    logic ack;
    i2c_start();
    send_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nack_addr got %b exp 0", ack); end
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL nack_state got %0d exp 0", dbg_state); end
    send_byte(8'h00, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nack_quiet got %b exp 0", ack); end
    i2c_stop();
  endtask

  task automatic test_page_write();
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pw_dev_ack got %b exp 1", ack); end
    send_byte(8'h1E, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pw_waddr_ack got %b exp 1", ack); end
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i), ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pw_data_ack[%0d] got %b exp 1", i, ack); end
    end
    i2c_stop();
    wait_clk(TWR + 100);
    // 0x18..0x1F after the in-page wrap
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h18, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pw_rd_ack got %b exp 1", ack); end
    for (int i = 0; i < 8; i++) begin
      recv_byte(i != 7, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL pw_read[%0d] got %h exp %h", i, d, e); end
    end
    i2c_stop();
  endtask

  task automatic test_seq_read_wrap();
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFE, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    i2c_stop();
    wait_clk(TWR + 100);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    send_byte(8'h33, ack);
    send_byte(8'h44, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sr_wr_ack got %b exp 1", ack); end
    i2c_stop();
    wait_clk(TWR + 100);
    exp_q = '{8'h11, 8'h22, 8'h33};
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFE, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) begin
      recv_byte(i != 2, d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL sr_read[%0d] got %h exp %h", i, d, e); end
    end
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL cur_rd_ack got %b exp 1", ack); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h44) begin errors++; $display("FAIL cur_rd_data got %h exp 44", d); end
    i2c_stop();
  endtask

  task automatic test_busy();
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    send_byte(8'h55, ack);
    i2c_stop();
    wait_clk(10);
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL busy_nack got %b exp 0", ack); end
    i2c_stop();
    wait_clk(TWR + 100);
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL busy_done_ack got %b exp 1", ack); end
    send_byte(8'h40, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL busy_data got %h exp 55", d); end
    i2c_stop();
    // dummy write must not open a busy window
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    i2c_stop();
    wait_clk(10);
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL dummy_no_busy got %b exp 1", ack); end
    i2c_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] d;
    logic [7:0] b;
    b = 8'hC3;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h60, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rm_waddr_ack got %b exp 1", ack); end
    for (int i = 7; i >= 4; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
    end
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_sda_oe got %b exp 0", sda_oe); end
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL rm_state got %0d exp 0", dbg_state); end
    i2c_stop();
    // pointer reset to 0, so a current-address read returns mem[0x00]
    i2c_start();
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rm_cur_ack got %b exp 1", ack); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL rm_cur_data got %h exp 33", d); end
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h60, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b0, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rm_mem_kept got %h exp ff", d); end
    i2c_stop();
  endtask

`ifdef AT24C02_WP_EN
  task automatic test_wp();
    logic ack;
    logic [7:0] d;
    wp = 1'b1;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack);
    send_byte(8'h3C, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wp_data_ack got %b exp 1", ack); end
    i2c_stop();
    wait_clk(10);
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wp_no_busy got %b exp 1", ack); end
    send_byte(8'h20, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    recv_byte(1'b0, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL wp_mem got %h exp ff", d); end
    i2c_stop();
    wp = 1'b0;
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_nack_addr();
    test_page_write();
    test_seq_read_wrap();
    test_busy();
    test_reset_mid();
`ifdef AT24C02_WP_EN
    test_wp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/at24c02_sim.md
# at24c02_sim

Synthesizable I2C target that emulates a 256-byte AT24C02 serial EEPROM, forming the far end of the bus driven by the EEPROM controller and I2C master. It decodes START/STOP, matches the 7-bit device address, and supports byte write, page write, current-address read, random read and sequential read. A built-in write-cycle busy window makes it NACK while "programming". It sits in the simulation/FPGA test harness, wired to the same open-drain SCL/SDA nets as the master.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit device address matched against the address byte.
- PAGE_BYTES, 8, page size; write pointer wraps within a page.
- TWR_CYCLES, 500, clk cycles after a write STOP during which the device NACKs its address; 0 disables.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL line level; the device never drives SCL.
- sda_i  in  1  SDA line level.
- sda_o  out  1  constant 0 (open-drain).
- sda_oe  out  1  1 = pull SDA low (ACK or data 0).
- wp  in  1  write protect; present only with AT24C02_WP_EN.

## Operation
- scl_i/sda_i pass through a 2-FF synchronizer, then edge detection. START = SDA fall while SCL high. STOP = SDA rise while SCL high. START/STOP are valid in every state, including repeated START.
- SDA is sampled on SCL rising edges. sda_oe changes only on detected SCL falling edges.
- States:
  - IDLE
  - DEVADDR: shift 8 bits on SCL rise.
  - DEV_ACK: ACK if addr==DEV_ADDR and not busy. Otherwise NACK and go to IDLE.
  - WADDR: R/W=0; receive the word address and load the 8-bit pointer.
  - WADDR_ACK
  - WDATA: receive a data byte.
  - WDATA_ACK: write mem[ptr], then ptr[2:0]++ with the upper bits held (page wrap).
  - RDATA: R/W=1; shift out mem[ptr] MSB-first, then ptr++ (wraps 8'hFF→8'h00).
  - RACK: sample the master ACK. ACK → RDATA. NACK → IDLE (release SDA, wait for STOP/START).
- Random read: WADDR followed by a repeated START with R/W=1; the read returns from the loaded pointer.
- The pointer persists across transactions. Reset sets ptr=0.
- STOP after at least one WDATA byte starts the busy counter at TWR_CYCLES. While it is nonzero, the device NACKs its address. STOP after only WADDR (dummy write) does not start the counter.
- Memory: 256×8, contents 8'hFF at time zero. rst does not clear memory.
- Reset mid-transaction: state=IDLE, sda_oe=0, ptr=0, busy counter=0, shift registers cleared.
- Reset values: sda_o=0, sda_oe=0.

## Timing
- clk must be ≥ 8× the SCL frequency (design point ~100 clk per SCL period).
- Input-to-internal latency is 2 clk (synchronizer) + 1 clk (edge register).
- ACK: sda_oe rises 1 clk after the internal SCL-fall following bit 8. It falls 1 clk after the next internal SCL fall.
- Read data: each bit is presented 1 clk after the internal SCL fall. The first read bit follows the falling edge that ends DEV_ACK.
- The memory write commits on the same clk that ACK is asserted.
- The busy counter decrements once per clk after STOP. The device accepts its address when the counter is 0 at the address ACK decision.

## Configuration
- AT24C02_WP_EN defined:
  - The wp port exists.
  - With wp=1, data bytes are still ACKed and the pointer still advances, but memory is not written and the busy window is not started.
- Undefined: no wp port, and writes are always performed.

## Structure
- Package at24c02_pkg holds:
  - the state enum type.
  - MEM_BYTES=256.
  - the default DEV_ADDR constant.
- Sub-module i2c_bus_sync contains the synchronizers, SCL rise/fall detection and START/STOP detection. Its outputs are single-cycle pulses.

## Test plan
- Byte write 0xA5 to addr 0x10, STOP, wait TWR_CYCLES, random read of 0x10 → returns 0xA5; every ACK slot shows sda_oe=1.
- Address 0x51 → NACK (sda_oe stays 0); state returns to IDLE with no SDA activity until the next START.
- Page write of 10 bytes 0x00..0x09 starting at 0x1E → mem[0x1E]=0x08, mem[0x1F]=0x09, mem[0x18..0x1D]=0x02..0x07.
- Sequential read of 3 bytes from 0xFE with NACK on the last → returns mem[0xFE], mem[0xFF], mem[0x00]; a following current-address read returns mem[0x01].
- Address byte sent 10 clk after a write STOP → NACK; after TWR_CYCLES → ACK.
- Assert rst during the bits of a WDATA byte → sda_oe=0 next clk; memory unchanged; a new transaction is decoded normally. With AT24C02_WP_EN and wp=1, a write of 0x3C to 0x20 is ACKed and mem[0x20] stays 0xFF.
